// File: rtl/de_operand_stage.sv
// -----------------------------------------------------------------------------
// de_operand_stage
//
// Decode -> Execute pipeline register. Captures both register-file read
// operands, the three register addresses, the extended immediate, the packed
// decode control word and a valid bit, with one cycle of latency.
//
// The register file writes on the rising edge and reads combinationally, so an
// operand read in the same cycle that writeback targets its register would be
// captured stale. This stage forwards writeback data into both the load path
// (decode addresses) and the held operands while stalled (E addresses).
// R15 is never forwarded: the register file supplies PC+8 for it.
//
// Per rising edge the priority is FLUSH_E > STALL_E > load. A flush loads an
// all-zero bubble; a stall holds every field except the held-operand forwarding.
//
// Ports:
//   CLK, RST_N                 clock (rising edge), async active-low reset
//   RA1_D, RA2_D, WA3_D        decode source / destination register addresses
//   RD1_D, RD2_D               register-file read data for RA1_D / RA2_D
//   EXTIMM_D, CTRL_D, VALID_D  extended immediate, control word, valid slot
//   WE3_W, RA3_W, WD3_W        writeback enable, destination and data
//   STALL_E, FLUSH_E           hazard-unit hold and bubble requests
//   RA1_E, RA2_E, WA3_E        registered addresses
//   RD1_E, RD2_E, EXTIMM_E     registered operands and immediate
//   CTRL_E, VALID_E            registered control word and valid
//   STALL_CNT, FLUSH_CNT       saturating performance counters
//
// Build option:
//   DE_OPERAND_STAGE_PERF_EN   when defined, STALL_CNT counts edges with a
//                              stall that is not overridden by a flush, and
//                              FLUSH_CNT counts edges with a flush; both
//                              saturate at all-ones. When undefined, both
//                              ports are tied to zero and no counter flops
//                              exist.
// -----------------------------------------------------------------------------
module de_operand_stage #(
  parameter int SIZE       = 32,
  parameter int AMOUNT_REG = 4,
  parameter int CTRL_W     = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  // Decode-side inputs
  input  logic [AMOUNT_REG-1:0] RA1_D,
  input  logic [AMOUNT_REG-1:0] RA2_D,
  input  logic [SIZE-1:0]       RD1_D,
  input  logic [SIZE-1:0]       RD2_D,
  input  logic [AMOUNT_REG-1:0] WA3_D,
  input  logic [SIZE-1:0]       EXTIMM_D,
  input  logic [CTRL_W-1:0]     CTRL_D,
  input  logic                  VALID_D,
  // Writeback port (same signals that drive the register file)
  input  logic                  WE3_W,
  input  logic [AMOUNT_REG-1:0] RA3_W,
  input  logic [SIZE-1:0]       WD3_W,
  // Hazard-unit control
  input  logic                  STALL_E,
  input  logic                  FLUSH_E,
  // Execute-side outputs
  output logic [AMOUNT_REG-1:0] RA1_E,
  output logic [AMOUNT_REG-1:0] RA2_E,
  output logic [AMOUNT_REG-1:0] WA3_E,
  output logic [SIZE-1:0]       RD1_E,
  output logic [SIZE-1:0]       RD2_E,
  output logic [SIZE-1:0]       EXTIMM_E,
  output logic [CTRL_W-1:0]     CTRL_E,
  output logic                  VALID_E,
  // Performance counters
  output logic [31:0]           STALL_CNT,
  output logic [31:0]           FLUSH_CNT
);

  // The program counter register; reads of it come from PC+8, not from a
  // stored value, so writeback data must never be forwarded into it.
  localparam logic [AMOUNT_REG-1:0] PC_REG = '1;

  // What the register does on the coming edge, already resolved by priority.
  typedef enum logic [1:0] {
    ACT_LOAD  = 2'd0,
    ACT_STALL = 2'd1,
    ACT_FLUSH = 2'd2
  } action_e;

  // All Execute-stage fields, kept together so a bubble is a single '0.
  typedef struct packed {
    logic [AMOUNT_REG-1:0] ra1;
    logic [AMOUNT_REG-1:0] ra2;
    logic [AMOUNT_REG-1:0] wa3;
    logic [SIZE-1:0]       rd1;
    logic [SIZE-1:0]       rd2;
    logic [SIZE-1:0]       extimm;
    logic [CTRL_W-1:0]     ctrl;
    logic                  valid;
  } e_regs_t;

  e_regs_t e_q;
  e_regs_t e_d;
  action_e action;

  // Forwarding qualifiers. The load path compares against the decode
  // addresses; the hold path compares against the captured addresses and only
  // matters when the held slot is a real instruction.
  logic load_byp1;
  logic load_byp2;
  logic hold_byp1;
  logic hold_byp2;

  assign load_byp1 = WE3_W && (RA3_W == RA1_D) && (RA1_D != PC_REG);
  assign load_byp2 = WE3_W && (RA3_W == RA2_D) && (RA2_D != PC_REG);
  assign hold_byp1 = WE3_W && e_q.valid && (RA3_W == e_q.ra1) && (e_q.ra1 != PC_REG);
  assign hold_byp2 = WE3_W && e_q.valid && (RA3_W == e_q.ra2) && (e_q.ra2 != PC_REG);

  // Flush dominates stall, stall dominates load.
  always_comb begin
    if (FLUSH_E) begin
      action = ACT_FLUSH;
    end else if (STALL_E) begin
      action = ACT_STALL;
    end else begin
      action = ACT_LOAD;
    end
  end

  // Next-state for the pipeline register.
  always_comb begin
    // NOTE: e_d is given a full default before any branch so every path
    // assigns it; a missed branch would otherwise infer a latch.
    e_d = e_q;
    unique case (action)
      ACT_FLUSH: begin
        e_d = '0;
      end
      ACT_STALL: begin
        // Held operands still pick up a writeback to their register,
        // otherwise the stalled instruction would leave with stale data.
        if (hold_byp1) e_d.rd1 = WD3_W;
        if (hold_byp2) e_d.rd2 = WD3_W;
      end
      default: begin
        e_d.ra1    = RA1_D;
        e_d.ra2    = RA2_D;
        e_d.wa3    = WA3_D;
        e_d.rd1    = load_byp1 ? WD3_W : RD1_D;
        e_d.rd2    = load_byp2 ? WD3_W : RD2_D;
        e_d.extimm = EXTIMM_D;
        e_d.ctrl   = CTRL_D;
        e_d.valid  = VALID_D;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // its inputs from before the edge, independent of process ordering.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      e_q <= '0;
    end else begin
      e_q <= e_d;
    end
  end

  // Outputs come straight from flops: no input-to-output combinational path.
  assign RA1_E    = e_q.ra1;
  assign RA2_E    = e_q.ra2;
  assign WA3_E    = e_q.wa3;
  assign RD1_E    = e_q.rd1;
  assign RD2_E    = e_q.rd2;
  assign EXTIMM_E = e_q.extimm;
  assign CTRL_E   = e_q.ctrl;
  assign VALID_E  = e_q.valid;

`ifdef DE_OPERAND_STAGE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // A stall overridden by a flush on the same edge does not count as a stall.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (FLUSH_E && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
      if (STALL_E && !FLUSH_E && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`else
  assign STALL_CNT = 32'h0;
  assign FLUSH_CNT = 32'h0;
`endif

endmodule

// File: tb/tb_de_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_de_operand_stage
//
// Self-checking bench for de_operand_stage. A reference model predicts the
// Execute-stage fields for every clock edge; predictions are queued when the
// inputs are driven and popped/compared one edge later. Each scenario task
// also compares the fields it is about against literal expected values.
// Build with +define+DE_OPERAND_STAGE_PERF_EN to exercise the counters.
// -----------------------------------------------------------------------------
module tb_de_operand_stage;

  localparam int SIZE = 32;
  localparam int AR   = 4;
  localparam int CW   = 16;

`ifdef DE_OPERAND_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            CLK;
  logic            RST_N;
  logic [AR-1:0]   RA1_D, RA2_D, WA3_D, RA3_W;
  logic [SIZE-1:0] RD1_D, RD2_D, EXTIMM_D, WD3_W;
  logic [CW-1:0]   CTRL_D;
  logic            VALID_D, WE3_W, STALL_E, FLUSH_E;
  logic [AR-1:0]   RA1_E, RA2_E, WA3_E;
  logic [SIZE-1:0] RD1_E, RD2_E, EXTIMM_E;
  logic [CW-1:0]   CTRL_E;
  logic            VALID_E;
  logic [31:0]     STALL_CNT, FLUSH_CNT;

  de_operand_stage #(.SIZE(SIZE), .AMOUNT_REG(AR), .CTRL_W(CW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .RA1_D(RA1_D), .RA2_D(RA2_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
    .WA3_D(WA3_D), .EXTIMM_D(EXTIMM_D), .CTRL_D(CTRL_D), .VALID_D(VALID_D),
    .WE3_W(WE3_W), .RA3_W(RA3_W), .WD3_W(WD3_W),
    .STALL_E(STALL_E), .FLUSH_E(FLUSH_E),
    .RA1_E(RA1_E), .RA2_E(RA2_E), .WA3_E(WA3_E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .EXTIMM_E(EXTIMM_E),
    .CTRL_E(CTRL_E), .VALID_E(VALID_E),
    .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AR-1:0]   ra1, ra2, wa3;
    logic [SIZE-1:0] rd1, rd2, imm;
    logic [CW-1:0]   ctrl;
    logic            valid;
    logic [31:0]     scnt, fcnt;
  } exp_t;

  exp_t model;
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference behaviour for one edge, given the inputs currently driven.
  function automatic exp_t predict(input exp_t cur);
    exp_t n;
    n = cur;
    if (FLUSH_E) begin
      n.ra1 = '0; n.ra2 = '0; n.wa3 = '0;
      n.rd1 = '0; n.rd2 = '0; n.imm = '0;
      n.ctrl = '0; n.valid = 1'b0;
    end else if (STALL_E) begin
      if (WE3_W && cur.valid && RA3_W == cur.ra1 && cur.ra1 != 4'hF) n.rd1 = WD3_W;
      if (WE3_W && cur.valid && RA3_W == cur.ra2 && cur.ra2 != 4'hF) n.rd2 = WD3_W;
    end else begin
      n.ra1 = RA1_D; n.ra2 = RA2_D; n.wa3 = WA3_D;
      n.rd1 = (WE3_W && RA3_W == RA1_D && RA1_D != 4'hF) ? WD3_W : RD1_D;
      n.rd2 = (WE3_W && RA3_W == RA2_D && RA2_D != 4'hF) ? WD3_W : RD2_D;
      n.imm = EXTIMM_D; n.ctrl = CTRL_D; n.valid = VALID_D;
    end
    if (PERF) begin
      if (FLUSH_E && cur.fcnt != 32'hFFFF_FFFF) n.fcnt = cur.fcnt + 32'd1;
      if (STALL_E && !FLUSH_E && cur.scnt != 32'hFFFF_FFFF) n.scnt = cur.scnt + 32'd1;
    end
    return n;
  endfunction

  // Pop the oldest prediction and compare it with what the DUT now shows.
  task automatic score();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_underflow: no prediction queued");
      return;
    end
    e = exp_q.pop_front();
    if ({RA1_E, RA2_E, WA3_E} !== {e.ra1, e.ra2, e.wa3}) begin
      errors++;
      $display("FAIL sb_addr: got %h/%h/%h want %h/%h/%h", RA1_E, RA2_E, WA3_E, e.ra1, e.ra2, e.wa3);
    end
    checks++;
    if ({RD1_E, RD2_E, EXTIMM_E} !== {e.rd1, e.rd2, e.imm}) begin
      errors++;
      $display("FAIL sb_data: got %h/%h/%h want %h/%h/%h", RD1_E, RD2_E, EXTIMM_E, e.rd1, e.rd2, e.imm);
    end
    checks++;
    if ({CTRL_E, VALID_E} !== {e.ctrl, e.valid}) begin
      errors++;
      $display("FAIL sb_ctrl: got %h/%b want %h/%b", CTRL_E, VALID_E, e.ctrl, e.valid);
    end
    checks++;
    if ({STALL_CNT, FLUSH_CNT} !== {e.scnt, e.fcnt}) begin
      errors++;
      $display("FAIL sb_cnt: got %h/%h want %h/%h", STALL_CNT, FLUSH_CNT, e.scnt, e.fcnt);
    end
  endtask

  // Predict, push, clock once, then sample 1ns after the edge and score.
  task automatic tick();
    model = predict(model);
    exp_q.push_back(model);
    @(posedge CLK);
    #1;
    score();
  endtask

  task automatic idle_inputs();
    RA1_D = '0; RA2_D = '0; WA3_D = '0; RD1_D = '0; RD2_D = '0;
    EXTIMM_D = '0; CTRL_D = '0; VALID_D = 1'b0;
    WE3_W = 1'b0; RA3_W = '0; WD3_W = '0;
    STALL_E = 1'b0; FLUSH_E = 1'b0;
  endtask

  // Asynchronous reset pulse placed between edges; model returns to zero.
  task automatic pulse_reset();
    #3;
    RST_N = 1'b0;
    model = '0;
    exp_q.delete();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST_N = 1'b0;
    model = '0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({RA1_E, RA2_E, WA3_E, RD1_E, RD2_E, EXTIMM_E, CTRL_E, VALID_E, STALL_CNT, FLUSH_CNT} !== '0) begin
      errors++;
      $display("FAIL reset_initial: got %h want 0", {RD1_E, RD2_E, CTRL_E, VALID_E});
    end
    RST_N = 1'b1;
    // Load something, then drop reset between edges.
    VALID_D = 1'b1; RD1_D = 32'hAAAA_0001; RA1_D = 4'd3; CTRL_D = 16'hFFFF;
    tick();
    #3;
    RST_N = 1'b0;
    model = '0;
    #1;
    checks++;
    if ({RA1_E, RD1_E, CTRL_E, VALID_E} !== '0) begin
      errors++;
      $display("FAIL reset_async: got ra1=%h rd1=%h ctrl=%h v=%b want 0", RA1_E, RD1_E, CTRL_E, VALID_E);
    end
    // A flush request while held in reset must neither load nor count.
    FLUSH_E = 1'b1;
    STALL_E = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if ({VALID_E, RD1_E, STALL_CNT, FLUSH_CNT} !== '0) begin
      errors++;
      $display("FAIL reset_dominates: got v=%b rd1=%h sc=%h fc=%h want 0", VALID_E, RD1_E, STALL_CNT, FLUSH_CNT);
    end
    idle_inputs();
    RST_N = 1'b1;
  endtask

  task automatic test_load();
    idle_inputs();
    RA1_D = 4'd2; RD1_D = 32'h0000_1234; RA2_D = 4'd3; RD2_D = 32'h0000_5678;
    WA3_D = 4'd4; EXTIMM_D = 32'hFFFF_FF80; CTRL_D = 16'hA5C3; VALID_D = 1'b1;
    tick();
    checks++;
    if ({RD1_E, RA1_E, VALID_E} !== {32'h0000_1234, 4'd2, 1'b1}) begin
      errors++;
      $display("FAIL load_plain: got rd1=%h ra1=%h v=%b want 00001234/2/1", RD1_E, RA1_E, VALID_E);
    end
    // An empty decode slot is still registered.
    VALID_D = 1'b0; CTRL_D = 16'h0F0F;
    tick();
    checks++;
    if ({VALID_E, CTRL_E} !== {1'b0, 16'h0F0F}) begin
      errors++;
      $display("FAIL load_invalid: got v=%b ctrl=%h want 0/0f0f", VALID_E, CTRL_E);
    end
  endtask

  task automatic test_load_bypass();
    idle_inputs();
    VALID_D = 1'b1;
    RA1_D = 4'd5; RD1_D = 32'h0; RA2_D = 4'd6; RD2_D = 32'h0000_2222;
    WE3_W = 1'b1; RA3_W = 4'd5; WD3_W = 32'hDEAD_BEEF;
    tick();
    checks++;
    if ({RD1_E, RD2_E} !== {32'hDEAD_BEEF, 32'h0000_2222}) begin
      errors++;
      $display("FAIL load_bypass: got rd1=%h rd2=%h want deadbeef/00002222", RD1_E, RD2_E);
    end
    // R15 is never forwarded.
    RA1_D = 4'd3; RD1_D = 32'h0000_0033; RA2_D = 4'hF; RD2_D = 32'h0000_0108;
    RA3_W = 4'hF; WD3_W = 32'hBAD0_BAD0;
    tick();
    checks++;
    if ({RD1_E, RD2_E} !== {32'h0000_0033, 32'h0000_0108}) begin
      errors++;
      $display("FAIL load_r15: got rd1=%h rd2=%h want 00000033/00000108", RD1_E, RD2_E);
    end
    // Both sources naming the written register both get forwarded.
    RA1_D = 4'd9; RA2_D = 4'd9; RD1_D = 32'h1; RD2_D = 32'h2;
    RA3_W = 4'd9; WD3_W = 32'h0BAD_CAFE;
    tick();
    checks++;
    if ({RD1_E, RD2_E} !== {32'h0BAD_CAFE, 32'h0BAD_CAFE}) begin
      errors++;
      $display("FAIL load_bypass_both: got rd1=%h rd2=%h want 0badcafe x2", RD1_E, RD2_E);
    end
    idle_inputs();
  endtask

  task automatic test_stall_bypass();
    idle_inputs();
    VALID_D = 1'b1; CTRL_D = 16'h1234;
    RA1_D = 4'd8; RD1_D = 32'h80; RA2_D = 4'd7; RD2_D = 32'h70; WA3_D = 4'd1;
    tick();
    // Change every decode input so a broken hold is visible.
    RA1_D = 4'd1; RA2_D = 4'd1; RD1_D = 32'hFFFF; RD2_D = 32'hFFFF;
    CTRL_D = 16'hEEEE; WA3_D = 4'd2; EXTIMM_D = 32'h77;
    STALL_E = 1'b1;
    tick();                                   // stall cycle 1
    checks++;
    if ({RA2_E, RD2_E, RD1_E} !== {4'd7, 32'h70, 32'h80}) begin
      errors++;
      $display("FAIL stall_hold: got ra2=%h rd2=%h rd1=%h want 7/70/80", RA2_E, RD2_E, RD1_E);
    end
    WE3_W = 1'b1; RA3_W = 4'd7; WD3_W = 32'h55;
    tick();                                   // stall cycle 2
    checks++;
    if ({RD2_E, RD1_E} !== {32'h55, 32'h80}) begin
      errors++;
      $display("FAIL stall_bypass: got rd2=%h rd1=%h want 55/80", RD2_E, RD1_E);
    end
    WE3_W = 1'b0;
    tick();                                   // stall cycle 3
    checks++;
    if ({RD2_E, RA2_E, CTRL_E, WA3_E} !== {32'h55, 4'd7, 16'h1234, 4'd1}) begin
      errors++;
      $display("FAIL stall_keep: got rd2=%h ra2=%h ctrl=%h wa3=%h want 55/7/1234/1", RD2_E, RA2_E, CTRL_E, WA3_E);
    end
    // Held R15 operand is not refreshed.
    STALL_E = 1'b0; RA1_D = 4'hF; RD1_D = 32'h108;
    tick();
    STALL_E = 1'b1; WE3_W = 1'b1; RA3_W = 4'hF; WD3_W = 32'h999;
    tick();
    checks++;
    if (RD1_E !== 32'h108) begin
      errors++;
      $display("FAIL stall_r15: got rd1=%h want 00000108", RD1_E);
    end
    idle_inputs();
  endtask

  task automatic test_flush_vs_stall();
    idle_inputs();
    pulse_reset();
    VALID_D = 1'b1; CTRL_D = 16'hBEEF; RA1_D = 4'd4; RD1_D = 32'h44;
    tick();
    STALL_E = 1'b1; FLUSH_E = 1'b1;
    tick();
    checks++;
    if ({VALID_E, CTRL_E, RD1_E, RA1_E} !== '0) begin
      errors++;
      $display("FAIL flush_bubble: got v=%b ctrl=%h rd1=%h ra1=%h want 0", VALID_E, CTRL_E, RD1_E, RA1_E);
    end
    checks++;
`ifdef DE_OPERAND_STAGE_PERF_EN
    if ({FLUSH_CNT, STALL_CNT} !== {32'd1, 32'd0}) begin
      errors++;
      $display("FAIL flush_counts: got fc=%0d sc=%0d want 1/0", FLUSH_CNT, STALL_CNT);
    end
`else
    if ({FLUSH_CNT, STALL_CNT} !== 64'd0) begin
      errors++;
      $display("FAIL flush_counts: got fc=%0d sc=%0d want 0/0", FLUSH_CNT, STALL_CNT);
    end
`endif
    idle_inputs();
  endtask

  task automatic test_saturation();
    idle_inputs();
`ifdef DE_OPERAND_STAGE_PERF_EN
    dut.stall_cnt_q = 32'hFFFF_FFFE;
    model.scnt = 32'hFFFF_FFFE;
`endif
    STALL_E = 1'b1;
    repeat (3) tick();
    checks++;
`ifdef DE_OPERAND_STAGE_PERF_EN
    if (STALL_CNT !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL stall_saturate: got %h want ffffffff", STALL_CNT);
    end
`else
    if ({STALL_CNT, FLUSH_CNT} !== 64'd0) begin
      errors++;
      $display("FAIL counters_absent: got sc=%h fc=%h want 0/0", STALL_CNT, FLUSH_CNT);
    end
`endif
    idle_inputs();
  endtask

  // Random mix of loads, stalls, flushes and writebacks; scoreboard only.
  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      RA1_D = 4'($urandom_range(0, 15));
      RA2_D = 4'($urandom_range(0, 15));
      WA3_D = 4'($urandom_range(0, 15));
      RD1_D = $urandom; RD2_D = $urandom; EXTIMM_D = $urandom;
      CTRL_D = 16'($urandom); VALID_D = 1'($urandom);
      WE3_W = 1'($urandom);
      RA3_W = ($urandom_range(0, 1) == 1) ? RA1_D : 4'($urandom_range(0, 15));
      WD3_W = $urandom;
      STALL_E = ($urandom_range(0, 3) == 0);
      FLUSH_E = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_load_bypass();
    test_stall_bypass();
    test_flush_vs_stall();
    test_saturation();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/de_operand_stage.md
Name: de_operand_stage

Overview:
- Decode→Execute pipeline register of the pipelined CPU.
- Captures the two register-file read operands, the destination, the extended immediate, the decode control word and a valid bit.
- The register file writes on the rising edge and reads combinationally. A register written by writeback in the same cycle it is read would otherwise be captured stale, so this stage bypasses writeback data into both the load path and the held (stalled) operands.
- Supports stall (hold) and flush (bubble) driven by the hazard unit.

Parameters:
- SIZE, 32, data width of operands and immediate
- AMOUNT_REG, 4, register address width
- CTRL_W, 16, width of the packed decode control word

Ports:
- CLK  input  1  clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- RA1_D  input  AMOUNT_REG  source register 1 address (decode)
- RA2_D  input  AMOUNT_REG  source register 2 address (decode)
- RD1_D  input  SIZE  register-file read data 1
- RD2_D  input  SIZE  register-file read data 2
- WA3_D  input  AMOUNT_REG  destination register (decode)
- EXTIMM_D  input  SIZE  extended immediate
- CTRL_D  input  CTRL_W  decode control word
- VALID_D  input  1  decode slot holds a real instruction
- WE3_W  input  1  writeback write enable (same signal driving the register file)
- RA3_W  input  AMOUNT_REG  writeback destination
- WD3_W  input  SIZE  writeback data
- STALL_E  input  1  hold all E registers
- FLUSH_E  input  1  load a bubble
- RA1_E, RA2_E, WA3_E  output  AMOUNT_REG  registered addresses
- RD1_E, RD2_E, EXTIMM_E  output  SIZE  registered operands and immediate
- CTRL_E  output  CTRL_W  registered control word
- VALID_E  output  1  registered valid
- STALL_CNT, FLUSH_CNT  output  32  performance counters (see Optional Feature)

Behaviour:
- Reset (RST_N=0, asynchronous): all outputs 0, including VALID_E=0 and CTRL_E=0.
- Per rising edge, priority is FLUSH_E > STALL_E > load.
- Flush:
  - VALID_E=0, CTRL_E=0, RD1_E/RD2_E/EXTIMM_E=0, addresses=0.
  - FLUSH_E and STALL_E both high: flush wins.
- Stall:
  - All fields hold, except held RD1_E/RD2_E are refreshed by the bypass rule below.
- Load:
  - All _D inputs are registered, one-cycle latency.
  - RD1_E = byp1 ? WD3_W : RD1_D, where byp1 = WE3_W && RA3_W==RA1_D && RA1_D!=4'b1111. Same for RD2.
- Held bypass: during stall, if WE3_W && RA3_W==RA1_E && RA1_E!=15 && VALID_E, then RD1_E<=WD3_W. Same for RD2_E.
- R15 (address 4'b1111) is never bypassed; the register file supplies PC+8 for it.
- Flush during reset deassertion: reset dominates.
- VALID_D=0 on load: still registered; VALID_E follows VALID_D.
- No combinational path from any input to any output.

Optional Feature:
- Macro: DE_OPERAND_STAGE_PERF_EN.
- Defined:
  - STALL_CNT increments on each edge with STALL_E=1 && !FLUSH_E.
  - FLUSH_CNT increments on each edge with FLUSH_E=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both ports are tied to 32'h0 and no counter flops are built.

Test Plan:
- Reset mid-operation: load VALID_D=1, RD1_D=32'hAAAA_0001, then pulse RST_N=0 between edges → all outputs 0 immediately, before the next edge.
- Plain load: RA1_D=2, RD1_D=32'h1234, WE3_W=0 → one edge later RD1_E=32'h1234, RA1_E=2, VALID_E=1.
- Load bypass: RA1_D=5, RD1_D=32'h0 (stale), WE3_W=1, RA3_W=5, WD3_W=32'hDEAD_BEEF → RD1_E=32'hDEAD_BEEF. Same with RA2_D=15, RA3_W=15 → RD2_E=RD2_D (no bypass).
- Stall with held bypass: RA2_E=7, STALL_E=1 for 3 cycles; on cycle 2, WE3_W=1, RA3_W=7, WD3_W=32'h55 → RD2_E=32'h55 from cycle 3 on; other fields unchanged.
- Flush versus stall: STALL_E=1 and FLUSH_E=1 on the same edge → VALID_E=0, CTRL_E=0. With DE_OPERAND_STAGE_PERF_EN defined: FLUSH_CNT=1, STALL_CNT=0.
- Counter saturation (PERF_EN defined): force STALL_CNT to 32'hFFFF_FFFE, stall 3 cycles → STALL_CNT=32'hFFFF_FFFF. With the macro undefined, both counters read 0 throughout.
